// File: rtl/ldr_memory_unit.sv
// Load/store memory stage: passes non-memory instructions through in one cycle and
// runs a two-state request/ack handshake with a bounded wait for loads and stores.
module ldr_memory_unit #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr_in,
   input  logic        valid_in,
   input  logic [31:0] addr_in,
   input  logic [31:0] str_data_in,
   output logic        stall_out,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] instr_out,
   output logic        valid_out,
   output logic [31:0] ldr_data_out,
   output logic        mem_err
);

   typedef enum logic {IDLE, REQ} state_t;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t      state, state_nxt;
   logic [7:0]  wait_cnt;
   logic [31:0] instr_lat;
   logic [6:0]  opcode;
   logic        is_load, is_store, is_mem, timeout_hit;

   assign opcode   = instr_in[27:21];
   assign is_load  = (opcode[6:4] == 3'b110) || (opcode[6:3] == 4'b1000);
   assign is_store = (opcode[6:4] == 3'b111) || (opcode[6:3] == 4'b1001);
   assign is_mem   = is_load || is_store;

   // Ack takes priority over the timeout in the same cycle.
   assign timeout_hit = (state == REQ) && !dmem_ack && (wait_cnt == WAIT_LAST);
   assign stall_out   = (state == REQ);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (valid_in && is_mem) state_nxt = REQ;
         REQ:  if (dmem_ack || timeout_hit) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         wait_cnt     <= 8'd0;
         instr_lat    <= 32'd0;
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_addr    <= 32'd0;
         dmem_wdata   <= 32'd0;
         instr_out    <= 32'd0;
         valid_out    <= 1'b0;
         ldr_data_out <= 32'd0;
         mem_err      <= 1'b0;
      end else begin
         state     <= state_nxt;
         valid_out <= 1'b0;
         mem_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (valid_in && is_mem) begin
                  instr_lat  <= instr_in;
                  dmem_req   <= 1'b1;
                  dmem_we    <= is_store;
                  dmem_addr  <= addr_in;
                  dmem_wdata <= str_data_in;
                  wait_cnt   <= 8'd0;
               end else if (valid_in) begin
                  instr_out <= instr_in;
                  valid_out <= 1'b1;
               end
            end
            REQ: begin
               if (dmem_ack) begin
                  dmem_req  <= 1'b0;
                  instr_out <= instr_lat;
                  valid_out <= 1'b1;
                  if (!dmem_we) ldr_data_out <= dmem_rdata;
               end else if (timeout_hit) begin
                  dmem_req <= 1'b0;
                  mem_err  <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ldr_memory_unit.sv
// Directed bench for ldr_memory_unit with TIMEOUT=4: pass-through, load, store,
// timeout, ack-on-timeout-cycle and reset-during-request scenarios.
module tb_ldr_memory_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr_in, addr_in, str_data_in, dmem_rdata;
   logic        valid_in, dmem_ack;
   logic        stall_out, dmem_req, dmem_we, valid_out, mem_err;
   logic [31:0] dmem_addr, dmem_wdata, instr_out, ldr_data_out;

   int n_total = 0;
   int n_pass  = 0;

   localparam logic [31:0] LD_INSTR = 32'h0C00_0000;  // opcode 7'b1100000
   localparam logic [31:0] ST_INSTR = 32'h0900_0000;  // opcode 7'b1001000

   ldr_memory_unit #(.TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .valid_in(valid_in),
      .addr_in(addr_in), .str_data_in(str_data_in), .stall_out(stall_out),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .instr_out(instr_out), .valid_out(valid_out), .ldr_data_out(ldr_data_out),
      .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs driven and outputs sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; valid_in = 1'b0; instr_in = 32'hFFFF_FFFF; addr_in = 32'hFFFF_FFFF;
      str_data_in = 32'hFFFF_FFFF; dmem_ack = 1'b0; dmem_rdata = 32'd0;
      step(); step();
      n_total++; if ({dmem_req, dmem_we, valid_out, mem_err, stall_out} !== 5'b0)
         $display("FAIL reset_ctl got=%b exp=00000", {dmem_req, dmem_we, valid_out, mem_err, stall_out}); else n_pass++;
      n_total++; if ({instr_out, ldr_data_out, dmem_addr, dmem_wdata} !== 128'd0)
         $display("FAIL reset_data got=%h exp=0", {instr_out, ldr_data_out, dmem_addr, dmem_wdata}); else n_pass++;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_pass_through();
      valid_in = 1'b1; instr_in = 32'h0000_0000;
      step();
      n_total++; if ({valid_out, stall_out, instr_out} !== {1'b1, 1'b0, 32'h0})
         $display("FAIL pass_zero got=%b/%b/%h exp=1/0/00000000", valid_out, stall_out, instr_out); else n_pass++;
      instr_in = 32'h1234_5678;
      step();
      n_total++; if ({valid_out, stall_out, instr_out} !== {1'b1, 1'b0, 32'h1234_5678})
         $display("FAIL pass_nz got=%b/%b/%h exp=1/0/12345678", valid_out, stall_out, instr_out); else n_pass++;
      valid_in = 1'b0; instr_in = 32'hAAAA_AAAA;
      step();
      n_total++; if ({valid_out, instr_out} !== {1'b0, 32'h1234_5678})
         $display("FAIL pass_idle got=%b/%h exp=0/12345678", valid_out, instr_out); else n_pass++;
   endtask

   task automatic test_load();
      valid_in = 1'b1; instr_in = LD_INSTR; addr_in = 32'h100; str_data_in = 32'h5555;
      step();
      // Upstream garbage while stalled must be ignored.
      instr_in = 32'h0000_0001; addr_in = 32'h999; str_data_in = 32'h7777;
      for (int c = 1; c <= 3; c++) begin
         n_total++; if ({dmem_req, dmem_we, stall_out, valid_out, dmem_addr} !== {4'b1010, 32'h100})
            $display("FAIL load_req_c%0d got=%b%b%b%b/%h exp=1010/00000100", c, dmem_req, dmem_we, stall_out, valid_out, dmem_addr); else n_pass++;
         if (c == 3) begin dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF; end
         step();
      end
      dmem_ack = 1'b0; dmem_rdata = 32'h0; valid_in = 1'b0;
      n_total++; if ({valid_out, dmem_req, stall_out, mem_err} !== 4'b1000)
         $display("FAIL load_done_ctl got=%b exp=1000", {valid_out, dmem_req, stall_out, mem_err}); else n_pass++;
      n_total++; if ({ldr_data_out, instr_out} !== {32'hDEAD_BEEF, LD_INSTR})
         $display("FAIL load_done_data got=%h/%h exp=deadbeef/%h", ldr_data_out, instr_out, LD_INSTR); else n_pass++;
      step();
      n_total++; if (valid_out !== 1'b0)
         $display("FAIL load_valid_pulse got=%b exp=0", valid_out); else n_pass++;
   endtask

   task automatic test_store();
      valid_in = 1'b1; instr_in = ST_INSTR; addr_in = 32'h200; str_data_in = 32'h1234;
      step();
      valid_in = 1'b0;
      n_total++; if ({dmem_req, dmem_we, stall_out, dmem_wdata, dmem_addr} !== {3'b111, 32'h1234, 32'h200})
         $display("FAIL store_req got=%b%b%b/%h/%h exp=111/00001234/00000200", dmem_req, dmem_we, stall_out, dmem_wdata, dmem_addr); else n_pass++;
      dmem_ack = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
      step();
      dmem_ack = 1'b0;
      n_total++; if ({valid_out, dmem_req, instr_out, ldr_data_out} !== {2'b10, ST_INSTR, 32'hDEAD_BEEF})
         $display("FAIL store_done got=%b%b/%h/%h exp=10/%h/deadbeef", valid_out, dmem_req, instr_out, ldr_data_out, ST_INSTR); else n_pass++;
      step();
   endtask

   task automatic test_timeout();
      valid_in = 1'b1; instr_in = LD_INSTR; addr_in = 32'h300;
      step();
      valid_in = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         n_total++; if ({dmem_req, stall_out, mem_err, valid_out} !== 4'b1100)
            $display("FAIL tmo_wait_c%0d got=%b exp=1100", c, {dmem_req, stall_out, mem_err, valid_out}); else n_pass++;
         step();
      end
      n_total++; if ({dmem_req, stall_out, mem_err, valid_out} !== 4'b0010)
         $display("FAIL tmo_abort got=%b exp=0010", {dmem_req, stall_out, mem_err, valid_out}); else n_pass++;
      step();
      n_total++; if ({mem_err, valid_out, dmem_req} !== 3'b000)
         $display("FAIL tmo_err_pulse got=%b exp=000", {mem_err, valid_out, dmem_req}); else n_pass++;
   endtask

   task automatic test_ack_on_timeout();
      valid_in = 1'b1; instr_in = LD_INSTR; addr_in = 32'h400;
      step();
      valid_in = 1'b0;
      step(); step(); step();
      n_total++; if (dmem_req !== 1'b1)
         $display("FAIL ackto_req4 got=%b exp=1", dmem_req); else n_pass++;
      dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
      step();
      dmem_ack = 1'b0;
      n_total++; if ({valid_out, mem_err, dmem_req, ldr_data_out} !== {3'b100, 32'hCAFE_F00D})
         $display("FAIL ackto_done got=%b%b%b/%h exp=100/cafef00d", valid_out, mem_err, dmem_req, ldr_data_out); else n_pass++;
      step();
      n_total++; if (mem_err !== 1'b0)
         $display("FAIL ackto_no_err got=%b exp=0", mem_err); else n_pass++;
   endtask

   task automatic test_reset_in_req();
      valid_in = 1'b1; instr_in = ST_INSTR; addr_in = 32'h500; str_data_in = 32'h6666;
      step();
      valid_in = 1'b0;
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      n_total++; if ({dmem_req, dmem_we, valid_out, mem_err, stall_out} !== 5'b0)
         $display("FAIL rstreq_ctl got=%b exp=00000", {dmem_req, dmem_we, valid_out, mem_err, stall_out}); else n_pass++;
      n_total++; if ({instr_out, ldr_data_out, dmem_addr, dmem_wdata} !== 128'd0)
         $display("FAIL rstreq_data got=%h exp=0", {instr_out, ldr_data_out, dmem_addr, dmem_wdata}); else n_pass++;
      valid_in = 1'b1; instr_in = 32'h0000_0042;
      step();
      valid_in = 1'b0;
      n_total++; if ({valid_out, stall_out, mem_err, instr_out} !== {3'b100, 32'h42})
         $display("FAIL rstreq_pass got=%b%b%b/%h exp=100/00000042", valid_out, stall_out, mem_err, instr_out); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_pass_through();
      test_load();
      test_store();
      test_timeout();
      test_ack_on_timeout();
      test_reset_in_req();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
